// File: rtl/serial_word_receiver_if.sv
// Serial bit input and parallel word output handshake of serial_word_receiver.
// The master drives the serial stream and out_ready; the slave returns the word.
interface serial_word_receiver_if #(
  parameter int WIDTH = 8
);
  logic             bit_en;
  logic             bit_in;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_par_err;

  modport master (
    output bit_en, bit_in, out_ready,
    input  out_data, out_valid, out_par_err
  );

  modport slave (
    input  bit_en, bit_in, out_ready,
    output out_data, out_valid, out_par_err
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Start-bit framed serial-to-parallel receiver, MSB first, optional even parity,
// feeding a one-entry valid/ready output register with a sticky overflow flag.
module serial_word_receiver #(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_receiver_if.slave bus,
  output logic                  overflow,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;

  logic [WIDTH-1:0] sr_next;
  logic             last_data;
  logic             done;
  logic [WIDTH-1:0] done_word;
  logic             done_err;
  logic             can_load;

  assign sr_next   = {sr[WIDTH-2:0], bus.bit_in};
  assign last_data = (cnt == CW'(WIDTH - 1));
  assign can_load  = !bus.out_valid || bus.out_ready;
  assign busy      = (state != IDLE);

  // NOTE: every output of this block gets a default first, otherwise paths
  // that skip an assignment infer latches.
  always_comb begin
    done      = 1'b0;
    done_word = sr;
    done_err  = 1'b0;
    if (bus.bit_en) begin
      case (state)
        DATA: if (last_data && PARITY == 0) begin
          done      = 1'b1;
          done_word = sr_next;
        end
        PAR: begin
          done     = 1'b1;
          done_err = ^{sr, bus.bit_in};
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      sr              <= '0;
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_par_err <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (bus.bit_en) begin
        case (state)
          IDLE: if (bus.bit_in) begin
            state <= DATA;
            cnt   <= '0;
          end
          DATA: begin
            sr  <= sr_next;
            cnt <= cnt + 1'b1;
            if (last_data) state <= (PARITY != 0) ? PAR : IDLE;
          end
          PAR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A completing frame wins over a plain transfer; a full, stalled
      // register drops the new word and keeps the held one.
      if (done && can_load) begin
        bus.out_data    <= done_word;
        bus.out_par_err <= done_err;
        bus.out_valid   <= 1'b1;
      end else if (done) begin
        overflow <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench: a no-parity and an even-parity receiver, each compared
// every cycle against a frame-level reference model, plus directed scenarios.
module tb_serial_word_receiver;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic en  [2];
  logic bi  [2];
  logic rdy [2];

  serial_word_receiver_if #(.WIDTH(W)) bus0 ();
  serial_word_receiver_if #(.WIDTH(W)) bus1 ();

  assign bus0.bit_en    = en[0];
  assign bus0.bit_in    = bi[0];
  assign bus0.out_ready = rdy[0];
  assign bus1.bit_en    = en[1];
  assign bus1.bit_in    = bi[1];
  assign bus1.out_ready = rdy[1];

  logic ovf0, busy0, ovf1, busy1;

  serial_word_receiver #(.WIDTH(W), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .overflow(ovf0), .busy(busy0)
  );
  serial_word_receiver #(.WIDTH(W), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .overflow(ovf1), .busy(busy1)
  );

  // Reference model, index k = instance, instance k has PARITY = k.
  bit          m_active [2];
  int          m_cnt    [2];
  int unsigned m_acc    [2];
  bit          m_valid  [2];
  logic [W-1:0] m_data  [2];
  bit          m_err    [2];
  bit          m_ovf    [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_cnt[k] = 0; m_acc[k] = 0;
      m_valid[k] = 0; m_data[k] = '0; m_err[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // One clock edge seen at frame level: collect bits after a start bit, and
  // once WIDTH+PARITY bits are in, form the word arithmetically.
  task automatic model_edge(input int k, input bit e, input bit b, input bit r);
    bit           done;
    logic [W-1:0] word;
    bit           err;
    int           need;
    need = W + k;
    done = 0;
    if (e) begin
      if (!m_active[k]) begin
        if (b) begin
          m_active[k] = 1; m_cnt[k] = 0; m_acc[k] = 0;
        end
      end else begin
        m_acc[k] = m_acc[k] * 2 + int'(b);
        m_cnt[k]++;
        if (m_cnt[k] == need) begin
          done = 1;
          m_active[k] = 0;
        end
      end
    end
    if (done) begin
      if (k == 1) begin
        word = W'(m_acc[k] / 2);
        err  = ($countones(m_acc[k]) % 2) == 1;
      end else begin
        word = W'(m_acc[k]);
        err  = 0;
      end
      if (!m_valid[k] || r) begin
        m_valid[k] = 1; m_data[k] = word; m_err[k] = err;
      end else begin
        m_ovf[k] = 1;
      end
    end else if (m_valid[k] && r) begin
      m_valid[k] = 0;
    end
  endtask

  task automatic compare_all();
    check("valid0", bus0.out_valid,   m_valid[0]);
    check("data0",  bus0.out_data,    m_data[0]);
    check("err0",   bus0.out_par_err, m_err[0]);
    check("ovf0",   ovf0,             m_ovf[0]);
    check("busy0",  busy0,            m_active[0]);
    check("valid1", bus1.out_valid,   m_valid[1]);
    check("data1",  bus1.out_data,    m_data[1]);
    check("err1",   bus1.out_par_err, m_err[1]);
    check("ovf1",   ovf1,             m_ovf[1]);
    check("busy1",  busy1,            m_active[1]);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after rising.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_edge(k, en[k], bi[k], rdy[k]);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Sends frame[len-1:0] MSB first on instance k; optional idle cycle with
  // garbage bit_in after every enabled bit.
  task automatic send(input int k, input logic [15:0] frame, input int len, input bit stall);
    for (int i = len - 1; i >= 0; i--) begin
      en[k] = 1'b1;
      bi[k] = frame[i];
      tick();
      if (stall) begin
        en[k] = 1'b0;
        bi[k] = 1'($urandom);
        tick();
      end
    end
    en[k] = 1'b0;
    bi[k] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; bi[k] = 1'b0; rdy[k] = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    @(negedge clk);

    // Reset held with random serial activity.
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        en[k] = 1'($urandom); bi[k] = 1'($urandom);
      end
      tick();
    end
    check("rst_valid0", bus0.out_valid, 0);
    check("rst_data0",  bus0.out_data,  0);
    check("rst_ovf0",   ovf0,           0);
    check("rst_busy0",  busy0,          0);
    check("rst_err1",   bus1.out_par_err, 0);
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; bi[k] = 1'b0;
    end
    rst = 1'b0;
    tick();

    // Basic frame 0xA5, continuous enable.
    rdy[0] = 1'b1;
    send(0, 16'h1A5, 9, 1'b0);
    check("basic_valid", bus0.out_valid, 1);
    check("basic_data",  bus0.out_data,  8'hA5);
    check("basic_busy",  busy0,          0);
    tick();
    check("basic_valid_once", bus0.out_valid, 0);

    // Same frame with bit_en alternating.
    en[0] = 1'b1; bi[0] = 1'b1;
    send(0, 16'h1A5, 9, 1'b1);
    check("stall_data", bus0.out_data, 8'hA5);
    tick();

    // Backpressure and overflow.
    rdy[0] = 1'b0;
    send(0, 16'h13C, 9, 1'b0);
    check("bp_first_valid", bus0.out_valid, 1);
    check("bp_first_data",  bus0.out_data,  8'h3C);
    check("bp_first_ovf",   ovf0,           0);
    send(0, 16'h1FF, 9, 1'b0);
    check("bp_held_data", bus0.out_data, 8'h3C);
    check("bp_ovf",       ovf0,          1);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    check("bp_drain_valid", bus0.out_valid, 0);
    check("bp_ovf_sticky",  ovf0,           1);

    // Completion on the same edge the held word is accepted.
    pulse_reset();
    send(0, 16'h13C, 9, 1'b0);
    send(0, 16'h0AA, 8, 1'b0);
    check("same_edge_pre_data", bus0.out_data, 8'h3C);
    rdy[0] = 1'b1; en[0] = 1'b1; bi[0] = 1'b1;
    tick();
    en[0] = 1'b0; bi[0] = 1'b0; rdy[0] = 1'b0;
    check("same_edge_valid", bus0.out_valid, 1);
    check("same_edge_data",  bus0.out_data,  8'h55);
    check("same_edge_ovf",   ovf0,           0);
    rdy[0] = 1'b1;
    tick();

    // Even parity on the PARITY=1 instance.
    rdy[1] = 1'b1;
    send(1, 16'h34A, 10, 1'b0);
    check("par_ok_data", bus1.out_data,    8'hA5);
    check("par_ok_err",  bus1.out_par_err, 0);
    tick();
    send(1, 16'h34B, 10, 1'b0);
    check("par_bad_data", bus1.out_data,    8'hA5);
    check("par_bad_err",  bus1.out_par_err, 1);
    tick();

    // Reset in mid-frame, then a full 0x81 frame.
    send(1, 16'h000D, 4, 1'b0);
    pulse_reset();
    rdy[1] = 1'b1;
    check("abort_busy",  busy1,          0);
    check("abort_valid", bus1.out_valid, 0);
    send(1, 16'h302, 10, 1'b0);
    check("after_abort_valid", bus1.out_valid,   1);
    check("after_abort_data",  bus1.out_data,    8'h81);
    check("after_abort_err",   bus1.out_par_err, 0);
    tick();
    check("after_abort_once", bus1.out_valid, 0);

    // Randomized traffic on both instances with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        en[k]  = ($urandom_range(0, 2) != 0);
        bi[k]  = 1'($urandom);
        rdy[k] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
